// File: rtl/cbrt_iter.sv
// Iterative 8-bit unsigned cube root: y = floor(cbrt(x)), 3 input bits per step.
// Each step uses a shift-add multiplier and a restoring compare, taking 15 cycles in total.
module cbrt_iter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] x_bi,
  output logic       busy_o,
  output logic [7:0] y_bo,
  output logic [1:0] state_o
);

  // Handshake: start_i is accepted on a rising edge only while busy_o is low
  // (IDLE). busy_o then stays high for 15 cycles. y_bo is valid on the first
  // cycle busy_o is low again and holds until the next completion.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] Y_SHIFT = 2'd1;
  localparam logic [1:0] MUL     = 2'd2;
  localparam logic [1:0] CMP     = 2'd3;

  logic [1:0]  state;
  logic [7:0]  x_r;
  logic [2:0]  y_r;
  logic [2:0]  s;
  logic [2:0]  op_a;
  logic [2:0]  op_m;
  logic [5:0]  prod;
  logic [1:0]  cnt;
  logic [15:0] b;
  logic        take;
  logic [2:0]  y_next;

  // b = (3*y*(y+1) + 1) << s, where y*(y+1) comes from the shift-add multiplier.
  always_comb begin
    b      = (({10'd0, prod} << 1) + {10'd0, prod} + 16'd1) << s;
    take   = ({8'd0, x_r} >= b);
    y_next = y_r + {2'b00, take};
  end

  assign state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      y_bo   <= 8'd0;
      x_r    <= 8'd0;
      y_r    <= 3'd0;
      s      <= 3'd0;
      op_a   <= 3'd0;
      op_m   <= 3'd0;
      prod   <= 6'd0;
      cnt    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            x_r    <= x_bi;
            y_r    <= 3'd0;
            s      <= 3'd6;
            state  <= Y_SHIFT;
            busy_o <= 1'b1;
          end
        end
        Y_SHIFT: begin
          y_r   <= {y_r[1:0], 1'b0};
          op_a  <= {y_r[1:0], 1'b0};
          op_m  <= {y_r[1:0], 1'b1};
          prod  <= 6'd0;
          cnt   <= 2'd0;
          state <= MUL;
        end
        MUL: begin
          if (op_m[cnt]) prod <= prod + ({3'd0, op_a} << cnt);
          cnt <= cnt + 2'd1;
          if (cnt == 2'd2) state <= CMP;
        end
        CMP: begin
          if (take) x_r <= x_r - b[7:0];
          y_r <= y_next;
          if (s == 3'd0) begin
            y_bo   <= {5'd0, y_next};
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            s     <= s - 3'd3;
            state <= Y_SHIFT;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbrt_iter.sv
// Randomized and directed bench for cbrt_iter. A cycle-level model of the handshake
// predicts busy timing and pushes the expected floor(cbrt(x)) for each accepted start.
module tb_cbrt_iter;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] x_bi = 8'd0;
  logic       busy_o;
  logic [7:0] y_bo;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_y = 8'd0;
  bit         model_busy = 1'b0;
  int         model_cnt = 0;
  bit         rst_at_edge = 1'b0;
  bit         prev_busy = 1'b0;

  cbrt_iter dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .x_bi    (x_bi),
    .busy_o  (busy_o),
    .y_bo    (y_bo),
    .state_o (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] cbrt_ref(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return 8'(r);
  endfunction

  // Reference model: an accepted start occupies exactly 15 cycles; reset wins.
  always @(posedge clk) begin
    rst_at_edge = rst_i;
    if (rst_i) begin
      model_busy = 1'b0;
      model_cnt  = 0;
      exp_q.delete();
      last_y     = 8'd0;
    end else if (!model_busy) begin
      if (start_i) begin
        exp_q.push_back(cbrt_ref(int'(x_bi)));
        model_busy = 1'b1;
        model_cnt  = 15;
      end
    end else begin
      model_cnt--;
      if (model_cnt == 0) model_busy = 1'b0;
    end
  end

  // Monitor / scoreboard: pops an expected root whenever the DUT drops busy.
  always @(negedge clk) begin
    if (prev_busy && !busy_o) begin
      if (exp_q.size() > 0) begin
        last_y = exp_q.pop_front();
      end else if (!rst_at_edge) begin
        checks++;
        errors++;
        $display("FAIL spurious_done t=%0t got result %0d with nothing outstanding", $time, y_bo);
      end
    end
    prev_busy = busy_o;
    checks++;
    if (busy_o !== model_busy) begin
      errors++;
      $display("FAIL busy t=%0t got %0b expected %0b", $time, busy_o, model_busy);
    end
    checks++;
    if (y_bo !== last_y) begin
      errors++;
      $display("FAIL y_bo t=%0t got %0d expected %0d", $time, y_bo, last_y);
    end
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] x);
    start_i = 1'b1;
    x_bi    = x;
    @(negedge clk);
    start_i = 1'b0;
    x_bi    = 8'($urandom_range(0, 255));
    cycles(15);
  endtask

  initial begin
    int cubes[7];
    int noncubes[6];
    cubes    = '{0, 1, 8, 27, 64, 125, 216};
    noncubes = '{7, 26, 63, 124, 215, 255};

    rst_i = 1'b1;
    cycles(3);
    rst_i = 1'b0;
    cycles(2);

    foreach (cubes[i]) run_op(8'(cubes[i]));
    foreach (noncubes[i]) run_op(8'(noncubes[i]));
    for (int v = 0; v < 256; v++) run_op(8'(v));
    repeat (30) run_op(8'($urandom_range(0, 255)));
    cycles(2);

    // Start while busy: pulses at cycles 3 and 10 must be ignored.
    start_i = 1'b1;
    x_bi    = 8'd216;
    @(negedge clk);
    start_i = 1'b0;
    cycles(2);
    start_i = 1'b1; x_bi = 8'd8;
    @(negedge clk);
    start_i = 1'b0;
    cycles(6);
    start_i = 1'b1; x_bi = 8'd8;
    @(negedge clk);
    start_i = 1'b0;
    cycles(10);

    // Reset mid-operation, then a fresh start.
    start_i = 1'b1;
    x_bi    = 8'd125;
    @(negedge clk);
    start_i = 1'b0;
    cycles(6);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    cycles(2);
    run_op(8'd27);
    cycles(2);

    // Reset and start together: the start is dropped.
    rst_i = 1'b1; start_i = 1'b1; x_bi = 8'd27;
    @(negedge clk);
    rst_i = 1'b0; start_i = 1'b0;
    cycles(3);

    // Continuous start with x_bi changing every cycle.
    run_op(8'd64);
    start_i = 1'b1;
    for (int c = 0; c < 16 * 6; c++) begin
      x_bi = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    start_i = 1'b0;
    cycles(20);

    // Result hold: 4 stays visible while x=1 is in flight.
    run_op(8'd64);
    run_op(8'd1);
    cycles(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbrt_iter.md
# cbrt_iter

Iterative 8-bit unsigned integer cube-root unit: y = floor(cbrt(x)). It sits directly upstream of the adder and square-root stage in the arithmetic top level, which computes y = sqrt(a + cbrt(b)). It takes b through a start/busy handshake and returns the 3-bit root zero-extended to 8 bits. It uses a restoring digit-by-digit algorithm (3 bits of input per step) with a small shift-add multiplier, so there is no combinational multiply on the datapath.

## Interface
- No parameters; all widths are fixed.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- x_bi  in  8  unsigned operand; sampled only in the cycle start_i is accepted.
- busy_o  out  1  registered; high while an operation is in flight.
- y_bo  out  8  result; bits [7:3] always 0; holds the last result until the next completion.

## Operation
- Internal registers:
  - x_r (8b): remainder.
  - y_r (3b): partial root.
  - s (0..6): shift; takes values 6, 3, 0.
  - op_a (3b), op_m (3b): multiplier operands.
  - prod (6b): product.
  - cnt (2b): multiplier bit counter.
- FSM states: IDLE, Y_SHIFT, MUL, CMP.
- IDLE, on start_i=1: x_r<=x_bi, y_r<=0, s<=6, go to Y_SHIFT. With start_i=0, stay in IDLE.
- Y_SHIFT: y_r<=y_r<<1; op_a<=y_r<<1; op_m<=(y_r<<1)+1; prod<=0; cnt<=0; go to MUL.
- MUL (3 cycles, cnt 0..2): if op_m[cnt] then prod<=prod+(op_a<<cnt). cnt<=cnt+1. Leave for CMP after cnt=2.
- CMP:
  - Compute b = (3*prod+1)<<s in 16-bit width, with no truncation.
  - If x_r >= b (zero-extended compare): x_r<=x_r-b and y_r<=y_r+1.
  - If s==0: y_bo<={5'b0, final y_r} and go to IDLE. Otherwise s<=s-3 and go to Y_SHIFT.
- Arithmetic bounds: y_r never exceeds 6; prod ≤ 42; b ≤ 127 at s=0 and ≤ 152 at s=3. The 16-bit b width is mandatory.
- start_i while busy_o=1 is ignored. x_bi changes while busy have no effect.
- busy_o = (state != IDLE), registered.

## Timing
- Reset values: state IDLE, busy_o 0, y_bo 0, all internal registers 0.
- Start is accepted at edge E0 (IDLE with start_i=1). busy_o is high from after E0 until edge E15 inclusive: exactly 15 cycles.
- Per 3-bit step: Y_SHIFT 1 cycle, MUL 3 cycles, CMP 1 cycle, for 5 cycles. Step edges: E1–E5, E6–E10, E11–E15.
- y_bo is updated at E15. busy_o falls in the same cycle y_bo becomes valid, so the consumer may sample y_bo on the first cycle busy_o=0.
- Back-to-back: start_i held high is accepted again at E16, the first IDLE cycle. This gives one result per 16 cycles.
- rst_i mid-operation: abort at the next edge, return to IDLE, busy_o 0, y_bo 0. No partial result is visible.
- rst_i and start_i high together: reset wins and the start is dropped.
- y_bo is unchanged during an operation; it shows the previous result or 0 after reset.

## Test plan
- Perfect cubes: x = 0, 1, 8, 27, 64, 125, 216 -> y_bo = 0, 1, 2, 3, 4, 5, 6, each with busy_o high exactly 15 cycles.
- Non-cubes and boundaries: x = 7, 26, 63, 124, 215, 255 -> 1, 2, 3, 4, 5, 6. Also sweep all 256 inputs against a floor(cbrt) model.
- Start while busy: start x=216, then pulse start_i with x_bi=8 at cycles 3 and 10 -> single result 6 at E15, and no second operation begins.
- Reset mid-operation: start x=125, assert rst_i at cycle 7 -> busy_o 0 and y_bo 0 next cycle. A fresh start with x=27 then gives 3 after 15 busy cycles.
- Continuous start_i=1 with x_bi changing every cycle -> accepts occur every 16 cycles. Each result equals cbrt of x_bi at its accept edge.
- Result hold: after x=64 gives 4, start x=1 -> y_bo stays 4 through all 15 busy cycles, then becomes 1.
